// File: rtl/sram_arbiter.sv
// Arbiter between IFU (read-only) and LSU (read/write) for a single-port SRAM.
// One transaction in flight at a time: grant, wait LATENCY cycles, hold response.
module sram_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_addr,
  output logic                  ifu_resp_valid,
  input  logic                  ifu_resp_ready,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic                  lsu_wen,
  input  logic [7:0]            lsu_wmask,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  output logic                  lsu_resp_valid,
  input  logic                  lsu_resp_ready,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  sram_en,
  output logic                  sram_wen,
  output logic [7:0]            sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic       GNT_IFU = 1'b0;
  localparam logic       GNT_LSU = 1'b1;
  localparam logic [3:0] LAT     = 4'(LATENCY);

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_last_grant;
  logic                  r_gnt;
  logic                  r_wen;
  logic [3:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_any_req;
  logic                  w_grant_id;

  // With both requesters valid, the one that was not served last wins.
  assign w_any_req  = ifu_req_valid | lsu_req_valid;
  assign w_grant_id = (ifu_req_valid && lsu_req_valid) ? ~r_last_grant : lsu_req_valid;

  // State, grant bookkeeping, latency counter and response data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= GNT_IFU;
      r_gnt        <= GNT_IFU;
      r_wen        <= 1'b0;
      r_cnt        <= 4'd0;
      r_data       <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_gnt        <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_wen        <= (w_grant_id == GNT_LSU) ? lsu_wen : 1'b0;
            r_cnt        <= LAT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_data <= r_wen ? '0 : sram_rdata;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Next state plus all outputs; everything is forced to zero while rst is high.
  always_comb begin
    w_next_state   = r_state;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    ifu_rdata      = '0;
    lsu_rdata      = '0;
    sram_en        = 1'b0;
    sram_wen       = 1'b0;
    sram_wmask     = 8'd0;
    sram_addr      = '0;
    sram_wdata     = '0;
    if (rst) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            w_next_state = WAIT;
            sram_en      = 1'b1;
            if (w_grant_id == GNT_LSU) begin
              lsu_req_ready = 1'b1;
              sram_wen      = lsu_wen;
              sram_wmask    = lsu_wmask;
              sram_addr     = lsu_addr;
              sram_wdata    = lsu_wdata;
            end else begin
              ifu_req_ready = 1'b1;
              sram_addr     = ifu_addr;
            end
          end else begin
            w_next_state = IDLE;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd1) begin
            w_next_state = RESP;
          end else begin
            w_next_state = WAIT;
          end
        end
        RESP: begin
          if (r_gnt == GNT_LSU) begin
            lsu_resp_valid = 1'b1;
            lsu_rdata      = r_data;
            w_next_state   = lsu_resp_ready ? IDLE : RESP;
          end else begin
            ifu_resp_valid = 1'b1;
            ifu_rdata      = r_data;
            w_next_state   = ifu_resp_ready ? IDLE : RESP;
          end
        end
        default: begin
          w_next_state = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter (LATENCY=1 and LATENCY=3 instances).
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
  logic [7:0]  lsu_wmask;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        sram_en, sram_wen;
  logic [7:0]  sram_wmask;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;

  logic        d3_ifu_req_valid, d3_ifu_req_ready, d3_ifu_resp_valid;
  logic [31:0] d3_ifu_rdata, d3_lsu_rdata;
  logic        d3_lsu_req_ready, d3_lsu_resp_valid;
  logic        d3_sram_en, d3_sram_wen;
  logic [7:0]  d3_sram_wmask;
  logic [31:0] d3_sram_addr, d3_sram_wdata, d3_sram_rdata;

  logic [31:0] mem [0:255];
  int          errors = 0;
  int          checks = 0;
  logic        exp_lsu;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_wmask(lsu_wmask), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  sram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .ifu_req_valid(d3_ifu_req_valid), .ifu_req_ready(d3_ifu_req_ready), .ifu_addr(32'h8000_0000),
    .ifu_resp_valid(d3_ifu_resp_valid), .ifu_resp_ready(1'b1), .ifu_rdata(d3_ifu_rdata),
    .lsu_req_valid(1'b0), .lsu_req_ready(d3_lsu_req_ready), .lsu_wen(1'b0),
    .lsu_wmask(8'd0), .lsu_addr(32'd0), .lsu_wdata(32'd0),
    .lsu_resp_valid(d3_lsu_resp_valid), .lsu_resp_ready(1'b1), .lsu_rdata(d3_lsu_rdata),
    .sram_en(d3_sram_en), .sram_wen(d3_sram_wen), .sram_wmask(d3_sram_wmask),
    .sram_addr(d3_sram_addr), .sram_wdata(d3_sram_wdata), .sram_rdata(d3_sram_rdata)
  );

  // SRAM model: read data registered on enable, byte-masked writes, word 0 preset on reset.
  always @(posedge clk) begin
    if (rst) begin
      mem[0] <= 32'h0000_0413;
    end else if (sram_en) begin
      if (sram_wen) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_wmask[b]) mem[sram_addr[9:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
      end else begin
        sram_rdata <= mem[sram_addr[9:2]];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; ifu_resp_ready = 1'b0;
    lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_wmask = 8'd0;
    lsu_addr = 32'd0; lsu_wdata = 32'd0; lsu_resp_ready = 1'b0;
    d3_ifu_req_valid = 1'b0; d3_sram_rdata = 32'd0;
    tick(); tick(); #1;
    chk_b("rst_ifu_req_ready", ifu_req_ready, 1'b0);
    chk_b("rst_sram_en", sram_en, 1'b0);
    chk_w("rst_state", 32'(dut.r_state), 32'd0);
    chk_b("rst_last_grant", dut.r_last_grant, 1'b0);
    chk_w("rst_data_reg", dut.r_data, 32'd0);

    // IFU read after reset
    rst = 1'b0; ifu_resp_ready = 1'b1; #1;
    chk_b("rd_ifu_req_ready", ifu_req_ready, 1'b1);
    chk_b("rd_sram_en", sram_en, 1'b1);
    chk_w("rd_sram_addr", sram_addr, 32'h8000_0000);
    chk_b("rd_sram_wen", sram_wen, 1'b0);
    chk_w("rd_sram_wmask", 32'(sram_wmask), 32'd0);
    chk_b("rd_lsu_req_ready", lsu_req_ready, 1'b0);
    tick(); ifu_req_valid = 1'b0; #1;
    chk_b("rd_wait_sram_en", sram_en, 1'b0);
    chk_b("rd_wait_resp_valid", ifu_resp_valid, 1'b0);
    tick(); #1;
    chk_b("rd_resp_valid", ifu_resp_valid, 1'b1);
    chk_w("rd_resp_rdata", ifu_rdata, 32'h0000_0413);
    chk_b("rd_lsu_resp_valid", lsu_resp_valid, 1'b0);
    tick(); #1;
    chk_w("rd_back_idle", 32'(dut.r_state), 32'd0);

    // LSU write then read of the same word
    lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_wmask = 8'h0F;
    lsu_addr = 32'h8000_0100; lsu_wdata = 32'hDEAD_BEEF; lsu_resp_ready = 1'b1; #1;
    chk_b("wr_lsu_req_ready", lsu_req_ready, 1'b1);
    chk_b("wr_sram_wen", sram_wen, 1'b1);
    chk_w("wr_sram_wmask", 32'(sram_wmask), 32'h0000_000F);
    chk_w("wr_sram_wdata", sram_wdata, 32'hDEAD_BEEF);
    tick(); lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_wmask = 8'd0; lsu_wdata = 32'd0; #1;
    chk_b("wr_wait_sram_wen", sram_wen, 1'b0);
    tick(); #1;
    chk_b("wr_ack_valid", lsu_resp_valid, 1'b1);
    chk_w("wr_ack_rdata", lsu_rdata, 32'd0);
    tick(); lsu_req_valid = 1'b1; #1;
    chk_b("lrd_sram_wen", sram_wen, 1'b0);
    chk_w("lrd_sram_addr", sram_addr, 32'h8000_0100);
    tick(); lsu_req_valid = 1'b0; #1;
    tick(); #1;
    chk_b("lrd_resp_valid", lsu_resp_valid, 1'b1);
    chk_w("lrd_rdata", lsu_rdata, 32'hDEAD_BEEF);
    tick();

    // Contention after reset: expect LSU, IFU, LSU, IFU
    rst = 1'b1; ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    tick(); rst = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      exp_lsu = (i % 2 == 0);
      chk_b("rr_lsu_req_ready", lsu_req_ready, exp_lsu);
      chk_b("rr_ifu_req_ready", ifu_req_ready, ~exp_lsu);
      tick(); #1;
      chk_b("rr_wait_lsu_ready", lsu_req_ready, 1'b0);
      chk_b("rr_wait_ifu_ready", ifu_req_ready, 1'b0);
      tick(); #1;
      chk_b("rr_lsu_resp_valid", lsu_resp_valid, exp_lsu);
      chk_b("rr_ifu_resp_valid", ifu_resp_valid, ~exp_lsu);
      chk_w("rr_lsu_rdata", lsu_rdata, exp_lsu ? 32'hDEAD_BEEF : 32'd0);
      chk_w("rr_ifu_rdata", ifu_rdata, exp_lsu ? 32'd0 : 32'h0000_0413);
      chk_b("rr_resp_ifu_ready", ifu_req_ready, 1'b0);
      if (i == 3) begin
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      end
      tick(); #1;
    end
    chk_b("rr_last_grant", dut.r_last_grant, 1'b0);

    // IFU response back-pressure with a waiting LSU request
    ifu_req_valid = 1'b1; ifu_resp_ready = 1'b0; #1;
    chk_b("bp_ifu_req_ready", ifu_req_ready, 1'b1);
    tick(); ifu_req_valid = 1'b0; lsu_req_valid = 1'b1; #1;
    tick(); #1;
    for (int i = 0; i < 5; i++) begin
      chk_b("bp_resp_valid", ifu_resp_valid, 1'b1);
      chk_w("bp_rdata", ifu_rdata, 32'h0000_0413);
      chk_b("bp_sram_en", sram_en, 1'b0);
      chk_b("bp_lsu_req_ready", lsu_req_ready, 1'b0);
      tick(); #1;
    end
    ifu_resp_ready = 1'b1; #1;
    chk_b("bp_hs_valid", ifu_resp_valid, 1'b1);
    chk_b("bp_hs_lsu_ready", lsu_req_ready, 1'b0);
    tick(); #1;
    chk_w("bp_idle", 32'(dut.r_state), 32'd0);
    chk_b("bp_lsu_granted", lsu_req_ready, 1'b1);
    tick(); lsu_req_valid = 1'b0; #1;
    tick(); #1;
    chk_b("bp_lsu_resp", lsu_resp_valid, 1'b1);
    tick(); #1;

    // Reset while an LSU read is in WAIT
    lsu_req_valid = 1'b1; #1;
    chk_b("mr_lsu_req_ready", lsu_req_ready, 1'b1);
    tick(); lsu_req_valid = 1'b0; rst = 1'b1; ifu_req_valid = 1'b1; #1;
    chk_b("mr_rst_ifu_ready", ifu_req_ready, 1'b0);
    chk_b("mr_rst_sram_en", sram_en, 1'b0);
    tick(); rst = 1'b0; ifu_req_valid = 1'b0; #1;
    chk_w("mr_state", 32'(dut.r_state), 32'd0);
    chk_b("mr_last_grant", dut.r_last_grant, 1'b0);
    chk_b("mr_lsu_resp", lsu_resp_valid, 1'b0);
    chk_b("mr_sram_en", sram_en, 1'b0);
    tick(); #1;
    chk_b("mr_no_resp_later", lsu_resp_valid, 1'b0);

    // LATENCY=3 instance: capture happens on the last WAIT cycle
    d3_ifu_req_valid = 1'b1; #1;
    chk_b("l3_grant_sram_en", d3_sram_en, 1'b1);
    chk_b("l3_grant_ready", d3_ifu_req_ready, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      tick(); d3_ifu_req_valid = 1'b0;
      d3_sram_rdata = (i == 3) ? 32'h1234_5678 : 32'hAAAA_AAAA; #1;
      chk_b("l3_wait_sram_en", d3_sram_en, 1'b0);
      chk_b("l3_wait_resp", d3_ifu_resp_valid, 1'b0);
    end
    tick(); #1;
    chk_b("l3_resp_valid", d3_ifu_resp_valid, 1'b1);
    chk_w("l3_rdata", d3_ifu_rdata, 32'h1234_5678);
    chk_b("l3_resp_sram_en", d3_sram_en, 1'b0);
    tick(); #1;
    chk_b("l3_resp_done", d3_ifu_resp_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Arbitrates the single-port simulation SRAM between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Sequences every access as grant, then wait, then response, with one transaction outstanding at a time.
- Registers read data so that requester back-pressure never depends on SRAM output hold.
- Sits between IFU/LSU and the Sram instance in the NPC core.

Parameters:
ADDR_WIDTH, 32, address width of requesters and SRAM
DATA_WIDTH, 32, data width of requesters and SRAM
LATENCY, 1, cycles from SRAM enable to rdata capture; legal range 1..15

Ports:
clk  in  1  single clock
rst  in  1  synchronous reset, active-high
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  ADDR_WIDTH  IFU read address
ifu_resp_valid  out  1  IFU read data valid
ifu_resp_ready  in  1  IFU consumes response
ifu_rdata  out  DATA_WIDTH  IFU read data
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_wen  in  1  1 = write, 0 = read
lsu_wmask  in  8  byte write mask
lsu_addr  in  ADDR_WIDTH  LSU address
lsu_wdata  in  DATA_WIDTH  LSU write data
lsu_resp_valid  out  1  LSU response (read data or write ack)
lsu_resp_ready  in  1  LSU consumes response
lsu_rdata  out  DATA_WIDTH  LSU read data; 0 for write ack
sram_en  out  1  SRAM enable
sram_wen  out  1  SRAM write enable
sram_wmask  out  8  SRAM byte mask
sram_addr  out  ADDR_WIDTH  SRAM address
sram_wdata  out  DATA_WIDTH  SRAM write data
sram_rdata  in  DATA_WIDTH  SRAM read data, valid from the cycle after enable

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. In the rst cycle all outputs are 0, the state is IDLE, last_grant = IFU, the wait counter is 0 and the data register is 0.
- FSM states:
  - IDLE: no transaction outstanding.
  - WAIT: SRAM access in flight.
  - RESP: response held for the requester.
- IDLE:
  - If any req_valid is high, grant one requester and assert its req_ready combinationally.
  - In the same cycle drive sram_en=1 and the granted requester's addr/wen/wmask/wdata.
  - IFU grants always drive sram_wen=0 and sram_wmask=0.
  - Record the grant id and req_wen, set counter=LATENCY, go to WAIT.
- Arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: round-robin; grant the requester that is not last_grant.
  - last_grant updates on every grant.
- Not-granted requester sees req_ready=0 and must hold its request (valid-ready rule; a request is not withdrawn before acceptance).
- SRAM outputs: sram_en=0 in every state other than the IDLE grant cycle. sram_addr/wdata/wmask are 0 when sram_en=0.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle where counter==1: if the access is a read, latch sram_rdata into the data register; if it is a write, latch 0. Go to RESP.
- RESP:
  - Assert the granted requester's resp_valid; its rdata = data register.
  - Stay until that requester's resp_ready=1, then go to IDLE.
  - req_ready stays 0 in RESP; no new grant is made in the handshake cycle.
- Non-granted requester: resp_valid=0 and rdata=0 at all times.
- Latency (LATENCY=1): grant at cycle T, WAIT at T+1, resp_valid from T+2. Best-case throughput is one transaction per 3 cycles.
- resp_ready asserted outside RESP is ignored. A req_valid arriving during WAIT or RESP waits until IDLE.
- Reset mid-operation (WAIT or RESP): return to IDLE and drop the pending response. A write already issued to the SRAM is not undone.

Test Plan:
- Read after reset: IFU read addr 0x80000000 with SRAM word 0x00000413 -> sram_en=1 at T, ifu_resp_valid=1 with ifu_rdata=0x00000413 at T+2, then IDLE.
- LSU write then read: write 0xDEADBEEF, wmask 0x0F, to 0x80000100, then read the same address -> sram_wen=1 only in the write grant cycle, lsu_rdata=0 on the ack, read returns 0xDEADBEEF.
- Contention: both valid for 4 transactions after reset -> grant order LSU, IFU, LSU, IFU; the loser's req_ready=0 while the other is served.
- Back-pressure: hold ifu_resp_ready=0 for 5 cycles -> ifu_resp_valid and ifu_rdata stable, sram_en=0, lsu_req_ready=0 throughout; IDLE the cycle after ready.
- LATENCY=3: IFU read -> resp_valid at T+4; sram_en asserted only at T.
- rst asserted in WAIT -> next cycle all outputs 0, state IDLE, no resp_valid, last_grant=IFU.
